// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard controller: load-use, multi-cycle EX hold, flush
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        ex_start,
    input  logic [5:0]  ex_cycles,
    input  logic        flush_req,
    output logic [5:0]  stall,
    output logic        flush,
    output logic        ex_busy,
    output logic        ex_done,
    output logic [31:0] stall_count
);

    // Hold patterns; bit5 is reserved and never set.
    localparam logic [5:0] STALL_NONE  = 6'b000000;
    localparam logic [5:0] STALL_LOAD  = 6'b000111;
    localparam logic [5:0] STALL_MULTI = 6'b001111;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_MULTI = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic [5:0]  stall_d;
    logic        flush_d;
    logic        ex_done_d;

    // State and remaining-cycle counter; reset wins over every request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and per-cycle outputs; priority is flush > multi-cycle hold > load-use.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_d   = STALL_NONE;
        flush_d   = 1'b0;
        ex_done_d = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (flush_req) begin
                    flush_d = 1'b1;
                    cnt_d   = 6'd0;
                end else if (ex_start && (ex_cycles != 6'd0)) begin
                    // This cycle is the first stalled one, so cnt holds the remainder.
                    stall_d = STALL_MULTI;
                    state_d = ST_MULTI;
                    cnt_d   = ex_cycles - 6'd1;
                end else if (stallreq_id) begin
                    stall_d = STALL_LOAD;
                end
            end
            ST_MULTI: begin
                if (flush_req) begin
                    // Abort the op: no completion pulse.
                    flush_d = 1'b1;
                    state_d = ST_RUN;
                    cnt_d   = 6'd0;
                end else if (cnt_q != 6'd0) begin
                    stall_d = STALL_MULTI;
                    cnt_d   = cnt_q - 6'd1;
                end else begin
                    // Release cycle; a load-use request here is re-sampled once back in RUN.
                    ex_done_d = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 6'd0;
            end
        endcase
    end

    // Saturating count of cycles with any hold active.
    always_comb begin
        stall_count_d = stall_count_q;
        if ((stall != STALL_NONE) && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Stall-cycle counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    // Outputs are quiet while reset is held so a mid-op reset never leaks a hold.
    always_comb begin
        stall   = rst ? STALL_NONE : stall_d;
        flush   = rst ? 1'b0 : flush_d;
        ex_done = rst ? 1'b0 : ex_done_d;
    end

    assign ex_busy     = (state_q == ST_MULTI);
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        ex_start;
    logic [5:0]  ex_cycles;
    logic        flush_req;
    logic [5:0]  stall;
    logic        flush;
    logic        ex_busy;
    logic        ex_done;
    logic [31:0] stall_count;

    int checks   = 0;
    int failures = 0;

    pipe_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_id (stallreq_id),
        .ex_start    (ex_start),
        .ex_cycles   (ex_cycles),
        .flush_req   (flush_req),
        .stall       (stall),
        .flush       (flush),
        .ex_busy     (ex_busy),
        .ex_done     (ex_done),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and apply a new input vector.
    task automatic drive(input logic r, input logic sr, input logic es,
                         input logic [5:0] ec, input logic fr);
        @(negedge clk);
        rst         = r;
        stallreq_id = sr;
        ex_start    = es;
        ex_cycles   = ec;
        flush_req   = fr;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; stallreq_id = 1'b0; ex_start = 1'b0; ex_cycles = 6'd0; flush_req = 1'b0;

        // Reset with inputs low
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        check("rst_stall", {26'd0, stall}, 32'h00);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_done", {31'd0, ex_done}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        idle();
        check("rst_busy", {31'd0, ex_busy}, 32'd0);
        check("rst_count", stall_count, 32'd0);

        // Reset mid-MULTI with cnt=5
        drive(1'b0, 1'b0, 1'b1, 6'd6, 1'b0);
        idle();
        check("mrst_busy_pre", {31'd0, ex_busy}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        check("mrst_stall_in_rst", {26'd0, stall}, 32'h00);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        idle();
        check("mrst_busy", {31'd0, ex_busy}, 32'd0);
        check("mrst_stall", {26'd0, stall}, 32'h00);
        check("mrst_count", stall_count, 32'd0);

        // ex_cycles=3
        drive(1'b0, 1'b0, 1'b1, 6'd3, 1'b0);
        check("m3_stall_t0", {26'd0, stall}, 32'h0F);
        idle();
        check("m3_stall_t1", {26'd0, stall}, 32'h0F);
        check("m3_busy_t1", {31'd0, ex_busy}, 32'd1);
        idle();
        check("m3_stall_t2", {26'd0, stall}, 32'h0F);
        check("m3_done_t2", {31'd0, ex_done}, 32'd0);
        idle();
        check("m3_stall_t3", {26'd0, stall}, 32'h00);
        check("m3_done_t3", {31'd0, ex_done}, 32'd1);
        check("m3_count", stall_count, 32'd3);
        idle();
        check("m3_busy_after", {31'd0, ex_busy}, 32'd0);
        check("m3_done_after", {31'd0, ex_done}, 32'd0);

        // ex_cycles=1
        drive(1'b0, 1'b0, 1'b1, 6'd1, 1'b0);
        check("m1_stall_t0", {26'd0, stall}, 32'h0F);
        idle();
        check("m1_stall_t1", {26'd0, stall}, 32'h00);
        check("m1_done_t1", {31'd0, ex_done}, 32'd1);
        check("m1_count", stall_count, 32'd4);

        // ex_cycles=0 with ex_start is ignored
        drive(1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
        check("m0_stall", {26'd0, stall}, 32'h00);
        check("m0_done", {31'd0, ex_done}, 32'd0);
        idle();
        check("m0_busy", {31'd0, ex_busy}, 32'd0);
        check("m0_done_next", {31'd0, ex_done}, 32'd0);
        check("m0_count", stall_count, 32'd4);

        // Load-use for two cycles
        drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
        check("lu_stall_t0", {26'd0, stall}, 32'h07);
        drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
        check("lu_stall_t1", {26'd0, stall}, 32'h07);
        check("lu_busy", {31'd0, ex_busy}, 32'd0);
        idle();
        check("lu_stall_t2", {26'd0, stall}, 32'h00);
        check("lu_count", stall_count, 32'd6);

        // flush + ex_start + stallreq together
        drive(1'b0, 1'b1, 1'b1, 6'd4, 1'b1);
        check("sim_flush", {31'd0, flush}, 32'd1);
        check("sim_stall", {26'd0, stall}, 32'h00);
        idle();
        check("sim_busy", {31'd0, ex_busy}, 32'd0);
        check("sim_count", stall_count, 32'd6);

        // Flush at cycle 2 of a 5-cycle op
        drive(1'b0, 1'b0, 1'b1, 6'd5, 1'b0);
        check("fl_stall_t0", {26'd0, stall}, 32'h0F);
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
        check("fl_flush", {31'd0, flush}, 32'd1);
        check("fl_stall", {26'd0, stall}, 32'h00);
        check("fl_done", {31'd0, ex_done}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            idle();
            check("fl_busy_after", {31'd0, ex_busy}, 32'd0);
            check("fl_done_after", {31'd0, ex_done}, 32'd0);
        end
        check("fl_count", stall_count, 32'd7);

        // Load-use during the MULTI release cycle is deferred to RUN
        drive(1'b0, 1'b0, 1'b1, 6'd2, 1'b0);
        idle();
        check("rel_stall_t1", {26'd0, stall}, 32'h0F);
        drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
        check("rel_stall_t2", {26'd0, stall}, 32'h00);
        check("rel_done_t2", {31'd0, ex_done}, 32'd1);
        check("rel_count_t2", stall_count, 32'd9);
        drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
        check("rel_stall_t3", {26'd0, stall}, 32'h07);
        check("rel_busy_t3", {31'd0, ex_busy}, 32'd0);

        // Saturation from a preloaded count
        @(negedge clk);
        dut.stall_count_q = 32'hFFFF_FFFE;
        stallreq_id = 1'b1;
        #1;
        drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
        check("sat_1", stall_count, 32'hFFFF_FFFF);
        drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
        check("sat_2", stall_count, 32'hFFFF_FFFF);
        idle();
        check("sat_3", stall_count, 32'hFFFF_FFFF);
        idle();
        check("sat_hold", stall_count, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port: stallreq_id  input  1  load-use hazard request from ID.
REQ-004 SHALL have port: ex_start  input  1  EX issues a multi-cycle op this cycle.
REQ-005 SHALL have port: ex_cycles  input  6  number of stall cycles the multi-cycle op needs; 0 means single-cycle.
REQ-006 SHALL have port: flush_req  input  1  exception/redirect flush request.
REQ-007 SHALL have port: stall  output  6  hold vector; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved (always 0).
REQ-008 SHALL have port: flush  output  1  clear all pipeline registers to NOP.
REQ-009 SHALL have port: ex_busy  output  1  high while in state MULTI.
REQ-010 SHALL have port: ex_done  output  1  one-cycle pulse on the cycle a multi-cycle op releases.
REQ-011 SHALL have port: stall_count  output  32  saturating count of cycles with stall != 0.

Function
REQ-012 SHALL implement FSM with two states: RUN and MULTI, plus 6-bit down-counter cnt.
REQ-013 stall, flush and ex_done SHALL be combinational from state, cnt and the current-cycle inputs; state, cnt and stall_count SHALL be registered.
REQ-014 Priority in every state SHALL be flush_req > multi-cycle hold > stallreq_id.
REQ-015 RUN, flush_req=1: flush=1, stall=0, next state RUN, cnt<=0.
REQ-016 RUN, ex_start=1 and ex_cycles!=0 (no flush): stall=6'b001111, next state MULTI, cnt<=ex_cycles-1.
REQ-017 RUN, ex_start=1 and ex_cycles=0: ex_start SHALL be ignored; stall decided by stallreq_id alone.
REQ-018 RUN, stallreq_id=1 only: stall=6'b000111 (PC, IF/ID, ID/EX hold; ID/EX consumer inserts bubble), state unchanged.
REQ-019 RUN, no request: stall=0.
REQ-020 MULTI, cnt!=0 (no flush): stall=6'b001111, cnt<=cnt-1; ex_start and stallreq_id SHALL be ignored.
REQ-021 MULTI, cnt=0 (no flush): stall=0, ex_done=1, next state RUN; a stallreq_id in this cycle SHALL be ignored (it is re-sampled in RUN).
REQ-022 MULTI, flush_req=1: flush=1, stall=0, ex_done=0, next state RUN, cnt<=0 (op aborted).
REQ-023 Total stalled cycles for an accepted multi-cycle op SHALL equal ex_cycles exactly; ex_done SHALL follow the last stalled cycle.
REQ-024 ex_busy SHALL be 1 iff state=MULTI.
REQ-025 stall_count SHALL increment by 1 at each clock edge where stall!=0 and SHALL hold at 32'hFFFFFFFF.
REQ-026 stall[5] SHALL always be 0; flush and stall!=0 SHALL never be asserted together.

Reset
REQ-027 On rst=1 at a clock edge: state<=RUN, cnt<=0, stall_count<=0; rst SHALL override all inputs, including mid-MULTI.
REQ-028 During and after reset, with inputs low: stall=0, flush=0, ex_busy=0, ex_done=0.

Verification
REQ-029 Reset: rst=1 for 2 cycles while in MULTI with cnt=5 -> after release state RUN, stall=0, ex_busy=0, stall_count=0.
REQ-030 Multi-cycle: ex_start=1, ex_cycles=3 at cycle T -> stall=6'b001111 at T, T+1, T+2; stall=0 and ex_done=1 at T+3; stall_count=3.
REQ-031 Edge lengths: ex_cycles=1 -> 1 stalled cycle then ex_done; ex_cycles=0 with ex_start=1 -> no stall, state RUN, ex_done never asserted.
REQ-032 Load-use: stallreq_id=1 for 2 cycles in RUN -> stall=6'b000111 for those 2 cycles, then 0; ex_busy=0 throughout.
REQ-033 Simultaneous: flush_req=1, ex_start=1, stallreq_id=1 in the same cycle -> flush=1, stall=0, state stays RUN. Flush at cycle 2 of a 5-cycle op -> flush=1 that cycle, ex_done never asserted, state RUN next cycle.
REQ-034 Saturation: preload stall_count to 32'hFFFFFFFE (force), then stall 3 cycles -> stall_count=32'hFFFFFFFF and it holds.
